// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment constants for the lap stopwatch.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment code; non-decimal codes blank.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_bcd,
  output logic [SEG_W-1:0]   o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    if (i_bcd <= 4'd9) o_seg_c = SEG_DIGIT[i_bcd];
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Parametrised BCD stopwatch with start/stop, lap freeze and clear.
// Display codes are registered one cycle behind the live or frozen count.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned NUM_DIGITS = 4,
  parameter logic [7:0]  SIX_MASK   = 8'b0000_0100,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          toggle,
  input  logic                          lap,
  output logic [SEG_W*NUM_DIGITS-1:0]   disp_time,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic                          running,
  output logic                          lap_active,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = DIGIT_W * NUM_DIGITS;
  localparam int unsigned SW = SEG_W * NUM_DIGITS;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_toggle_q;
  logic                  r_lap_q;
  logic [PW-1:0]         r_presc;
  logic [BW-1:0]         r_lap;
  logic [SW-1:0]         r_disp;
  logic                  r_running;
  logic                  r_lap_active;
  logic                  r_overflow;

  logic                  w_tg;
  logic                  w_lp;
  logic                  w_counting;
  logic                  w_tick;
  logic                  w_full;
  logic                  w_sat;
  logic                  w_capture;
  logic                  w_clear;
  logic                  w_running_nxt;
  logic                  w_lap_active_nxt;
  logic [NUM_DIGITS-1:0] w_atmax;
  logic [BW-1:0]         w_bcd;
  logic [BW-1:0]         w_src;
  logic [SW-1:0]         w_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle_q <= 1'b0;
      r_lap_q    <= 1'b0;
    end else begin
      r_toggle_q <= toggle;
      r_lap_q    <= lap;
    end
  end

  assign w_tg = toggle & ~r_toggle_q;
  assign w_lp = lap & ~r_lap_q;

  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_tick     = w_counting && (r_presc == PW'(TICK_DIV - 1));
  assign w_full     = w_tick & (&w_atmax);
  assign w_sat      = w_full & ~WRAP;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Toggle beats lap; a saturating overflow forces a stop from either counting state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_tg) w_state_nxt = RUN;
      RUN: begin
        if (w_sat || w_tg) w_state_nxt = PAUSE;
        else if (w_lp)     w_state_nxt = LAP;
      end
      LAP: begin
        if (w_sat || w_tg) w_state_nxt = PAUSE;
        else if (w_lp)     w_state_nxt = RUN;
      end
      PAUSE: begin
        if (w_tg)      w_state_nxt = RUN;
        else if (w_lp) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_running_nxt    = (w_state_nxt == RUN) || (w_state_nxt == LAP);
    w_lap_active_nxt = (w_state_nxt == LAP);
    w_capture        = (r_state == RUN) && (w_state_nxt == LAP);
    w_clear          = (r_state == PAUSE) && (w_state_nxt == IDLE);
  end

  // Prescaler holds its phase through PAUSE
  always_ff @(posedge clk) begin
    if (reset || w_clear || (r_state == IDLE)) r_presc <= '0;
    else if (w_counting)                       r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [DIGIT_W-1:0]    MAXV = SIX_MASK[i] ? 4'd5 : 4'd9;
    localparam logic [NUM_DIGITS-1:0] LOW  = NUM_DIGITS'((1 << i) - 1);

    logic [DIGIT_W-1:0] r_d;
    logic               w_cin;

    assign w_cin      = w_tick && ((w_atmax & LOW) == LOW);
    assign w_atmax[i] = (r_d == MAXV);

    always_ff @(posedge clk) begin
      if (reset || w_clear)    r_d <= '0;
      else if (w_cin && !w_sat) r_d <= (r_d == MAXV) ? '0 : r_d + 4'd1;
    end

    assign w_bcd[DIGIT_W*i +: DIGIT_W] = r_d;

    bcd_to_seg7 u_seg (
      .i_bcd   (w_src[DIGIT_W*i +: DIGIT_W]),
      .o_seg_c (w_seg[SEG_W*i +: SEG_W])
    );
  end

  assign w_src = (r_state == LAP) ? r_lap : w_bcd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lap        <= '0;
      r_disp       <= {NUM_DIGITS{SEG_DIGIT[0]}};
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_capture) r_lap <= w_bcd;
      r_disp       <= w_seg;
      r_running    <= w_running_nxt;
      r_lap_active <= w_lap_active_nxt;
      if (w_clear)     r_overflow <= 1'b0;
      else if (w_full) r_overflow <= 1'b1;
    end
  end

  assign disp_time  = r_disp;
  assign bcd        = w_bcd;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: wrapping and saturating instances share stimulus and
// are compared every cycle against an elapsed-tick reference model.
module tb_stopwatch_lap;

  localparam int TD = 4;
  localparam int MAXN = 5999;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

  logic        clk = 1'b0;
  logic        reset, toggle, lap;
  logic [27:0] disp_w, disp_s;
  logic [15:0] bcd_w, bcd_s;
  logic        run_w, lapa_w, ovf_w, run_s, lapa_s, ovf_s;

  always #5 clk = ~clk;

  stopwatch_lap #(.TICK_DIV(TD), .NUM_DIGITS(4), .SIX_MASK(8'b0000_0100), .WRAP(1'b1)) u_dut_wrap (
    .clk(clk), .reset(reset), .toggle(toggle), .lap(lap),
    .disp_time(disp_w), .bcd(bcd_w), .running(run_w), .lap_active(lapa_w), .overflow(ovf_w));

  stopwatch_lap #(.TICK_DIV(TD), .NUM_DIGITS(4), .SIX_MASK(8'b0000_0100), .WRAP(1'b0)) u_dut_sat (
    .clk(clk), .reset(reset), .toggle(toggle), .lap(lap),
    .disp_time(disp_s), .bcd(bcd_s), .running(run_s), .lap_active(lapa_s), .overflow(ovf_s));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 600) % 10), 4'((n / 100) % 6), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] disp_of(input int n);
    logic [15:0] b;
    b = to_bcd(n);
    return {seg_of(b[15:12]), seg_of(b[11:8]), seg_of(b[7:4]), seg_of(b[3:0])};
  endfunction

  // Reference model: count kept as elapsed ticks, index 0 wraps, index 1 saturates
  int m_st[2], m_n[2], m_ph[2], m_lapv[2], m_disp[2];
  bit m_ovf[2];
  bit m_tq, m_lq, m_valid = 1'b0;

  task automatic model_step();
    bit tg, lp;
    tg = toggle && !m_tq;
    lp = lap && !m_lq;
    m_tq = reset ? 1'b0 : toggle;
    m_lq = reset ? 1'b0 : lap;
    for (int w = 0; w < 2; w++) begin
      int st, ns;
      bit cnt, tick, full, sat;
      if (reset) begin
        m_st[w] = M_IDLE; m_n[w] = 0; m_ph[w] = 0; m_lapv[w] = 0; m_disp[w] = 0; m_ovf[w] = 1'b0;
      end else begin
        st = m_st[w];
        m_disp[w] = (st == M_LAP) ? m_lapv[w] : m_n[w];
        cnt  = (st == M_RUN) || (st == M_LAP);
        tick = cnt && (m_ph[w] == TD - 1);
        full = tick && (m_n[w] == MAXN);
        sat  = full && (w == 1);
        ns = st;
        case (st)
          M_IDLE:  if (tg) ns = M_RUN;
          M_RUN:   if (sat || tg) ns = M_PAUSE; else if (lp) ns = M_LAP;
          M_LAP:   if (sat || tg) ns = M_PAUSE; else if (lp) ns = M_RUN;
          default: if (tg) ns = M_RUN; else if (lp) ns = M_IDLE;
        endcase
        if (st == M_RUN && ns == M_LAP) m_lapv[w] = m_n[w];
        if (tick) begin
          if (full) begin
            m_ovf[w] = 1'b1;
            if (w == 0) m_n[w] = 0;
          end else begin
            m_n[w] = m_n[w] + 1;
          end
        end
        if (cnt) m_ph[w] = tick ? 0 : m_ph[w] + 1;
        else if (st == M_IDLE) m_ph[w] = 0;
        if (st == M_PAUSE && ns == M_IDLE) begin
          m_n[w] = 0; m_ph[w] = 0; m_ovf[w] = 1'b0;
        end
        m_st[w] = ns;
      end
    end
    m_valid = 1'b1;
  endtask

  function automatic logic [2:0] flags_of(input int w);
    return {m_st[w] == M_RUN || m_st[w] == M_LAP, m_st[w] == M_LAP, m_ovf[w]};
  endfunction

  always begin
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) begin
      check_eq("wrap.bcd",   32'(bcd_w), 32'(to_bcd(m_n[0])));
      check_eq("wrap.disp",  32'(disp_w), 32'(disp_of(m_disp[0])));
      check_eq("wrap.flags", 32'({run_w, lapa_w, ovf_w}), 32'(flags_of(0)));
      check_eq("sat.bcd",    32'(bcd_s), 32'(to_bcd(m_n[1])));
      check_eq("sat.disp",   32'(disp_s), 32'(disp_of(m_disp[1])));
      check_eq("sat.flags",  32'({run_s, lapa_s, ovf_s}), 32'(flags_of(1)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; toggle = 1'b0; lap = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    toggle = 1'b1;
    cyc(1);
    toggle = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      cyc(1);
      reset = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 15) == 0) toggle = ~toggle;
      if ($urandom_range(0, 19) == 0) lap = ~lap;
    end
  endtask

  localparam logic [27:0] D0000 = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
  localparam logic [27:0] D0012 = {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100};
  localparam logic [27:0] D0020 = {7'b1000000, 7'b1000000, 7'b0100100, 7'b1000000};

  initial begin
    reset = 1'b1; toggle = 1'b0; lap = 1'b0;
    cyc(3);
    check_eq("rst.bcd", 32'(bcd_w), 32'h0);
    check_eq("rst.disp", 32'(disp_w), 32'(D0000));
    check_eq("rst.flags", 32'({run_s, lapa_s, ovf_s}), 32'h0);
    reset = 1'b0;

    random_phase(3000);

    // Start latency and carry through the six-counting digit
    do_reset();
    start_pulse();
    check_eq("start.running", 32'(run_w), 32'h1);
    cyc(3);
    check_eq("start.pre_tick", 32'(bcd_w), 32'h0);
    cyc(1);
    check_eq("start.first_tick", 32'(bcd_w), 32'h0001);
    cyc(1);
    check_eq("start.seg1", 32'(disp_w[6:0]), 32'(7'b1111001));
    cyc(2391);
    check_eq("carry.599", 32'(bcd_w), 32'h0599);
    cyc(4);
    check_eq("carry.600", 32'(bcd_w), 32'h1000);

    // Lap freeze and release, pause, clear, simultaneous edges
    do_reset();
    start_pulse();
    cyc(48);
    check_eq("lap.at12", 32'(bcd_w), 32'h0012);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check_eq("lap.active", 32'(lapa_w), 32'h1);
    cyc(31);
    check_eq("lap.live20", 32'(bcd_w), 32'h0020);
    check_eq("lap.frozen", 32'(disp_w), 32'(D0012));
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check_eq("lap.release_lag", 32'(disp_w), 32'(D0012));
    cyc(1);
    check_eq("lap.released", 32'(disp_w), 32'(D0020));
    cyc(58);
    check_eq("pause.at35", 32'(bcd_w), 32'h0035);
    toggle = 1'b1;
    cyc(1);
    toggle = 1'b0;
    check_eq("pause.running", 32'(run_w), 32'h0);
    cyc(40);
    check_eq("pause.hold", 32'(bcd_w), 32'h0035);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    check_eq("clear.bcd", 32'(bcd_w), 32'h0);
    check_eq("clear.flags", 32'({run_w, lapa_w, ovf_w}), 32'h0);
    start_pulse();
    cyc(5);
    toggle = 1'b1; lap = 1'b1;
    cyc(1);
    toggle = 1'b0; lap = 1'b0;
    check_eq("both.flags", 32'({run_w, lapa_w}), 32'h0);

    // Reset while frozen
    do_reset();
    start_pulse();
    cyc(168);
    check_eq("rlap.at42", 32'(bcd_w), 32'h0042);
    lap = 1'b1;
    cyc(1);
    check_eq("rlap.active", 32'(lapa_w), 32'h1);
    lap = 1'b0; reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_eq("rlap.bcd", 32'(bcd_w), 32'h0);
    check_eq("rlap.disp", 32'(disp_w), 32'(D0000));
    check_eq("rlap.flags", 32'({run_w, lapa_w, ovf_w}), 32'h0);
    cyc(3);
    check_eq("rlap.after", 32'(disp_w), 32'(D0000));

    // Overflow in both modes
    do_reset();
    start_pulse();
    cyc(4 * MAXN);
    check_eq("ovf.wrap_max", 32'(bcd_w), 32'h9599);
    check_eq("ovf.sat_max", 32'(bcd_s), 32'h9599);
    cyc(4);
    check_eq("ovf.wrap_bcd", 32'(bcd_w), 32'h0);
    check_eq("ovf.wrap_flags", 32'({run_w, ovf_w}), 32'h3);
    check_eq("ovf.sat_bcd", 32'(bcd_s), 32'h9599);
    check_eq("ovf.sat_flags", 32'({run_s, ovf_s}), 32'h1);
    cyc(8);
    check_eq("ovf.sat_hold", 32'(bcd_s), 32'h9599);

    random_phase(2000);
    reset = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
